// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, control-flow opcodes and
// sequencer state encoding. Also used by the decoder.
package cpu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'h00;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'h18;
    localparam logic [OPC_W-1:0] OP_JZ   = 5'h19;
    localparam logic [OPC_W-1:0] OP_JNZ  = 5'h1A;
    localparam logic [OPC_W-1:0] OP_JC   = 5'h1B;
    localparam logic [OPC_W-1:0] OP_JNC  = 5'h1C;
    localparam logic [OPC_W-1:0] OP_CALL = 5'h1D;
    localparam logic [OPC_W-1:0] OP_RET  = 5'h1E;
    localparam logic [OPC_W-1:0] OP_HLT  = 5'h1F;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/branch_unit.sv
// Next-PC resolution for control-flow opcodes, plus the stack strobes for
// CALL/RET. Purely combinational; strobes only fire while exec is high.
module branch_unit
    import cpu_pkg::*;
(
    input  logic             exec,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flags_z,
    input  logic             flags_c,
    input  logic [7:0]       pc,
    input  logic [7:0]       target,
    input  logic [7:0]       pop_data,
    output logic [7:0]       next_pc,
    output logic [7:0]       push_data,
    output logic             push_enable,
    output logic             pop_enable,
    output logic             halt
);

    logic [7:0] pc_inc;

    // 8-bit add wraps 8'hFF to 8'h00, which is the intended PC behaviour.
    assign pc_inc    = pc + 8'd1;
    assign push_data = pc_inc;

    always_comb begin
        next_pc     = pc_inc;
        push_enable = 1'b0;
        pop_enable  = 1'b0;
        halt        = 1'b0;
        if (exec) begin
            case (opcode)
                OP_JMP:  next_pc = target;
                OP_JZ:   next_pc = flags_z  ? target : pc_inc;
                OP_JNZ:  next_pc = !flags_z ? target : pc_inc;
                OP_JC:   next_pc = flags_c  ? target : pc_inc;
                OP_JNC:  next_pc = !flags_c ? target : pc_inc;
                OP_CALL: begin
                    push_enable = 1'b1;
                    next_pc     = target;
                end
                OP_RET: begin
                    pop_enable = 1'b1;
                    next_pc    = pop_data;
                end
                OP_HLT: begin
                    halt    = 1'b1;
                    next_pc = pc;
                end
                default: next_pc = pc_inc;
            endcase
        end
    end

endmodule

// File: rtl/sequencer.sv
// Fetch/execute sequencer: FETCH -> LOAD -> EXEC per instruction, owns the PC,
// latches the instruction for the decoder and resolves control flow.
module sequencer
    import cpu_pkg::*;
#(
    parameter int         INSTR_WIDTH = 24,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    output logic [7:0]             rom_addr,
    output logic                   rom_enable,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   flags_z,
    input  logic                   flags_c,
    output logic                   stack_push_enable,
    output logic [7:0]             stack_push_data,
    output logic                   stack_pop_enable,
    input  logic [7:0]             stack_pop_data,
    output logic                   halted
);

    seq_state_t             state, next_state;
    logic [7:0]             pc;
    logic [7:0]             next_pc;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   exec;
    logic                   bu_halt;

    // A reset landing on an EXEC cycle must not leak a stack push/pop.
    assign exec = (state == ST_EXEC) && !rst;

    branch_unit u_branch (
        .exec        (exec),
        .opcode      (instr_q[INSTR_WIDTH-1 -: OPC_W]),
        .flags_z     (flags_z),
        .flags_c     (flags_c),
        .pc          (pc),
        .target      (instr_q[7:0]),
        .pop_data    (stack_pop_data),
        .next_pc     (next_pc),
        .push_data   (stack_push_data),
        .push_enable (stack_push_enable),
        .pop_enable  (stack_pop_enable),
        .halt        (bu_halt)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: next_state = hold ? ST_FETCH : ST_LOAD;
            ST_LOAD:  next_state = ST_EXEC;
            ST_EXEC:  next_state = bu_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            instr_q <= '0;
        end else begin
            state <= next_state;
            if (state == ST_LOAD) instr_q <= rom_data;
            if (state == ST_EXEC) pc <= next_pc;
        end
    end

    assign rom_addr    = pc;
    assign rom_enable  = (state == ST_FETCH) && !hold;
    assign instr       = instr_q;
    assign instr_valid = (state == ST_EXEC);
    assign halted      = (state == ST_HALT);

endmodule

// File: doc/sequencer.md
# sequencer

Fetch/execute sequencer for the 8-bit CPU: owns the program counter, addresses the instruction ROM, latches each 24-bit instruction for the decoder, and resolves control-flow opcodes (jumps, conditional branches on Z/C, CALL/RET through the hardware stack, HLT). It sits between `rom` and `decoder` in `top`. It issues a one-cycle execute strobe so GPR, flag and stack writes happen exactly once per instruction.

## Interface
Parameters:
- `INSTR_WIDTH`, 24: instruction width; opcode is `instr[INSTR_WIDTH-1 -: 5]`, branch target is `instr[7:0]`.
- `RESET_PC`, 8'h00: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  pause request; sampled only in FETCH.
- `rom_addr`  out  8  ROM read address (= PC).
- `rom_enable`  out  1  ROM read strobe.
- `rom_data`  in  INSTR_WIDTH  ROM read data, valid one cycle after `rom_enable`.
- `instr`  out  INSTR_WIDTH  latched instruction to decoder.
- `instr_valid`  out  1  execute strobe; decoder qualifies all write enables with it.
- `flags_z`, `flags_c`  in  1 each  current flag register outputs.
- `stack_push_enable`  out  1  push return address (CALL).
- `stack_push_data`  out  8  return address.
- `stack_pop_enable`  out  1  pop return address (RET).
- `stack_pop_data`  in  8  top of stack, valid combinationally while non-empty.
- `halted`  out  1  high in HALT.

## Operation
- States: FETCH, LOAD, EXEC, HALT.
- FETCH: `rom_enable`=1, `rom_addr`=PC. If `hold`=1: `rom_enable`=0, stay in FETCH. Else -> LOAD.
- LOAD: capture `rom_data` into `instr` at end of cycle -> EXEC.
- EXEC: `instr_valid`=1 for exactly this cycle; compute next PC -> FETCH (HALT for HLT).
- Next PC in EXEC, by opcode: JMP 5'h18: target. JZ 5'h19: target if `flags_z` else PC+1. JNZ 5'h1A: target if !`flags_z`. JC 5'h1B: target if `flags_c`. JNC 5'h1C: target if !`flags_c`. CALL 5'h1D: `stack_push_enable`=1, `stack_push_data`=PC+1, PC=target. RET 5'h1E: `stack_pop_enable`=1, PC=`stack_pop_data`. HLT 5'h1F: PC unchanged -> HALT. Any other opcode (NOP 5'h00, ALU/GPR ops): PC+1.
- PC+1 is modulo 256: 8'hFF -> 8'h00; CALL at 8'hFF pushes 8'h00.
- Stack strobes only ever assert in EXEC, only for CALL/RET; `top` ORs them with the decoder's stack strobes, and the decoder emits none for opcodes 5'h18–5'h1F.
- HALT: all strobes 0, `halted`=1; exits only on `rst`.
- Stack overflow/underflow are the stack's behaviour; RET on empty loads whatever `stack_pop_data` presents.

## Timing
- Reset (any state, any cycle incl. mid-EXEC): at the next edge state=FETCH, PC=`RESET_PC`, `instr`=0, `halted`=0. The EXEC of an interrupted instruction is not completed: no push/pop, no PC change. In the cycle after reset: `rom_enable`=1 (0 if `hold`), `rom_addr`=`RESET_PC`, `instr_valid`=0, stack strobes 0.
- All outputs are Moore functions of state/PC/`instr` except `rom_enable` (depends on `hold`) and the RET PC update (samples `stack_pop_data` in EXEC).
- 3 cycles per instruction without hold; each `hold` cycle adds one.
- Branches use flag values present during EXEC; flags written by the previous instruction's EXEC edge are visible (no hazard).
- `instr` stable from end of LOAD until end of the following LOAD.

## Structure
- Opcode constants (JMP…HLT, NOP), opcode field position and state encoding go in shared `cpu_pkg`, also used by `decoder`.
- Single module; next-PC/branch resolution is a natural combinational sub-module `branch_unit` (opcode, flags, PC, target, pop data -> next PC, push/pop strobes).

## Test plan
- Reset, ROM of NOPs, `hold`=0 -> `rom_addr` 0,1,2 in FETCH every 3 cycles; `instr_valid` single-cycle pulse each third cycle.
- JZ 8'h40 at PC 5 with Z=1 -> next fetch 8'h40; same with Z=0 -> 8'h06; repeat JC/JNC with C.
- CALL 8'h80 at PC 8'h10 -> push 8'h11 for one cycle, fetch 8'h80; RET there (pop data 8'h11) -> one pop pulse, fetch 8'h11.
- NOP at 8'hFF -> next fetch 8'h00; CALL at 8'hFF pushes 8'h00.
- HLT -> `halted`=1, no further `rom_enable`/`instr_valid` for 20 cycles; `rst` -> fetch from `RESET_PC`.
- `rst` during EXEC of CALL -> no push, next fetch `RESET_PC`; `hold`=1 for 4 cycles in FETCH -> `rom_enable`=0, PC unchanged, then resumes.
